// File: rtl/line_buffer_feeder.sv
// Streams one zero-padded projection line per angle into the line buffer,
// then holds line_valid until the back-projector acknowledges it.
module line_buffer_feeder #(
    parameter int pNoTaps      = 4,
    parameter int pTapsWidth   = 4,
    parameter int pDataLength  = 16,
    parameter int pLineLength  = pNoTaps * pTapsWidth,
    parameter int pCntLength   = 16,
    parameter int pNoOfAngles  = 180,
    parameter int pAngleLength = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [pDataLength-1:0]  in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [pDataLength-1:0]  lb_shift_in,
    output logic                    lb_enable,
    output logic                    line_valid,
    input  logic                    line_ack,
    output logic [pAngleLength-1:0] angle,
    output logic                    frame_done,
    output logic                    len_err
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        FULL
    } state_t;

    localparam logic [pCntLength-1:0]   kLastCount = pCntLength'(pLineLength - 1);
    localparam logic [pAngleLength-1:0] kLastAngle = pAngleLength'(pNoOfAngles - 1);

    state_t                state;
    logic [pCntLength-1:0] count;
    logic                  accept;

    assign accept = in_valid & in_ready;

    // count tracks shifts issued for the current line; the Lth shift always
    // ends the line, so surplus samples simply wait for the next angle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            in_ready    <= 1'b0;
            lb_shift_in <= '0;
            lb_enable   <= 1'b0;
            line_valid  <= 1'b0;
            angle       <= '0;
            frame_done  <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            lb_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FILL;
                        in_ready   <= 1'b1;
                        angle      <= '0;
                        count      <= '0;
                        frame_done <= 1'b0;
                        len_err    <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        lb_enable   <= 1'b1;
                        lb_shift_in <= in_data;
                        count       <= count + pCntLength'(1);
                        if (count == kLastCount) begin
                            state    <= FULL;
                            in_ready <= 1'b0;
                            if (!in_last) begin
                                len_err <= 1'b1;
                            end
                        end else if (in_last) begin
                            state    <= PAD;
                            in_ready <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    lb_enable   <= 1'b1;
                    lb_shift_in <= '0;
                    count       <= count + pCntLength'(1);
                    if (count == kLastCount) begin
                        state <= FULL;
                    end
                end
                // The first FULL cycle still carries the final shift pulse,
                // so line_valid rises one cycle later and only then is ack honoured.
                FULL: begin
                    if (!line_valid) begin
                        line_valid <= 1'b1;
                    end else if (line_ack) begin
                        line_valid <= 1'b0;
                        count      <= '0;
                        if (angle == kLastAngle) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            angle    <= angle + pAngleLength'(1);
                            state    <= FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Drives projection lines into line_buffer_feeder and compares every line
// buffer shift and status flag against a queue-based line model.
module tb_line_buffer_feeder;

    localparam int kTaps   = 4;
    localparam int kWidth  = 4;
    localparam int kData   = 16;
    localparam int kLine   = kTaps * kWidth;
    localparam int kCnt    = 8;
    localparam int kAngles = 3;
    localparam int kAngleW = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [kData-1:0]   in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               line_ack = 1'b0;
    logic               in_ready;
    logic [kData-1:0]   lb_shift_in;
    logic               lb_enable;
    logic               line_valid;
    logic [kAngleW-1:0] angle;
    logic               frame_done;
    logic               len_err;

    int testsRun = 0;
    int testsFailed = 0;

    logic [kData-1:0] expShifts[$];
    int   lineCnt = 0;
    logic expLenErr = 1'b0;
    int   shiftsThisLine = 0;
    logic prevEnable = 1'b0;
    logic prevLineValid = 1'b0;

    always #5 clk = ~clk;

    line_buffer_feeder #(
        .pNoTaps(kTaps), .pTapsWidth(kWidth), .pDataLength(kData),
        .pLineLength(kLine), .pCntLength(kCnt), .pNoOfAngles(kAngles),
        .pAngleLength(kAngleW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .lb_shift_in(lb_shift_in), .lb_enable(lb_enable), .line_valid(line_valid),
        .line_ack(line_ack), .angle(angle), .frame_done(frame_done), .len_err(len_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // A line is exactly kLine shifts: accepted samples first, zeros after a short in_last.
    task automatic modelAccept(input logic [kData-1:0] d, input logic last);
        expShifts.push_back(d);
        lineCnt++;
        if (lineCnt == kLine) begin
            if (!last) expLenErr = 1'b1;
            lineCnt = 0;
        end else if (last) begin
            while (lineCnt < kLine) begin
                expShifts.push_back('0);
                lineCnt++;
            end
            lineCnt = 0;
        end
    endtask

    task automatic applyStimulus(input logic [kData-1:0] d, input logic last);
        int   guard = 0;
        logic accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!accepted && guard < 300) begin
            if (in_ready) begin
                accepted = 1'b1;
                modelAccept(d, last);
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic startFrame();
        expLenErr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_in_ready", in_ready, 1);
        checkOutput("start_angle", angle, 0);
        checkOutput("start_frame_done", frame_done, 0);
        checkOutput("start_len_err", len_err, 0);
    endtask

    task automatic waitLineValid();
        int guard = 0;
        while (!line_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("line_valid_timeout", line_valid, 1);
    endtask

    task automatic pulseAck();
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
    endtask

    task automatic ackLine(input int nextAngle);
        waitLineValid();
        repeat (4) @(negedge clk);
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_line_valid", line_valid, 1);
        pulseAck();
        checkOutput("ack_line_valid", line_valid, 0);
        checkOutput("ack_angle", angle, nextAngle);
        checkOutput("ack_in_ready", in_ready, 1);
    endtask

    task automatic sendRandomLine();
        int len = $urandom_range(1, kLine);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            applyStimulus(kData'($urandom_range(0, 65535)), i == len - 1);
        end
    endtask

    // Shift monitor: every lb_enable pulse must match the model queue in order.
    always @(negedge clk) begin
        if (!reset_n) begin
            shiftsThisLine = 0;
            prevEnable = 1'b0;
            prevLineValid = 1'b0;
        end else begin
            if (lb_enable) begin
                shiftsThisLine++;
                if (expShifts.size() == 0)
                    checkOutput("shift_queue", 32'(expShifts.size()), 32'd1);
                else
                    checkOutput("shift_data", lb_shift_in, expShifts.pop_front());
            end
            if (line_valid && !prevLineValid) begin
                checkOutput("lv_after_last_shift", prevEnable, 1);
                checkOutput("lv_enable_low", lb_enable, 0);
                checkOutput("line_shift_count", shiftsThisLine, kLine);
                checkOutput("line_len_err", len_err, expLenErr);
                shiftsThisLine = 0;
            end
            prevEnable = lb_enable;
            prevLineValid = line_valid;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_lb_enable", lb_enable, 0);
        checkOutput("rst_lb_shift_in", lb_shift_in, 0);
        checkOutput("rst_line_valid", line_valid, 0);
        checkOutput("rst_angle", angle, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_len_err", len_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", in_ready, 0);

        // Frame 1: long line, held surplus sample, short line, gapped line.
        startFrame();
        for (int i = 1; i <= kLine; i++) applyStimulus(kData'(i), 1'b0);
        fork
            applyStimulus(16'h0111, 1'b0);
            ackLine(1);
        join
        checkOutput("long_len_err_sticky", len_err, 1);
        for (int i = 2; i <= 5; i++) applyStimulus(kData'(16'h0110 + i), i == 5);
        ackLine(2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(kData'(16'hA000 + i), i == 7);
            @(negedge clk);
        end
        waitLineValid();
        repeat (4) @(negedge clk);
        pulseAck();
        checkOutput("frame_done", frame_done, 1);
        checkOutput("done_in_ready", in_ready, 0);
        checkOutput("done_line_valid", line_valid, 0);
        pulseAck();
        repeat (2) @(negedge clk);
        checkOutput("extra_ack_frame_done", frame_done, 1);
        checkOutput("extra_ack_line_valid", line_valid, 0);
        checkOutput("extra_ack_in_ready", in_ready, 0);

        // Frame 2: exact full line, then reset part-way through angle 1.
        startFrame();
        for (int i = 1; i <= kLine; i++) applyStimulus(kData'(i), i == kLine);
        ackLine(1);
        for (int i = 1; i <= 7; i++) applyStimulus(kData'(16'h0200 + i), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_lb_enable", lb_enable, 0);
        checkOutput("mid_rst_lb_shift_in", lb_shift_in, 0);
        checkOutput("mid_rst_line_valid", line_valid, 0);
        checkOutput("mid_rst_angle", angle, 0);
        checkOutput("mid_rst_frame_done", frame_done, 0);
        checkOutput("mid_rst_len_err", len_err, 0);
        expShifts.delete();
        lineCnt = 0;
        expLenErr = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 0);

        // Frame 3: randomized lines after the restart.
        startFrame();
        sendRandomLine();
        ackLine(1);
        sendRandomLine();
        ackLine(2);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
